// File: rtl/btn_move_pkg.sv
// Shared types and constants for the move-command front end: direction
// encoding, button count, debouncer state type and the press priority encoder.
package btn_move_pkg;

  localparam int NUM_BTN = 4;

  typedef logic [1:0] move_dir_t;

  localparam move_dir_t DIR_UP    = 2'd0;
  localparam move_dir_t DIR_DOWN  = 2'd1;
  localparam move_dir_t DIR_LEFT  = 2'd2;
  localparam move_dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    DB_LO      = 2'd0,
    DB_WAIT_HI = 2'd1,
    DB_HI      = 2'd2,
    DB_WAIT_LO = 2'd3
  } db_state_t;

  // Pulse vector is {R,L,D,U}; U wins over D over L over R.
  function automatic move_dir_t prio_dir(input logic [NUM_BTN-1:0] pulses);
    move_dir_t dir;
    if (pulses[0]) begin
      dir = DIR_UP;
    end else if (pulses[1]) begin
      dir = DIR_DOWN;
    end else if (pulses[2]) begin
      dir = DIR_LEFT;
    end else begin
      dir = DIR_RIGHT;
    end
    return dir;
  endfunction

endpackage

// File: rtl/btn_move_tx_debounce.sv
// One pushbutton: 2-FF synchronizer, four-state debounce FSM with a stability
// counter, registered debounced level and a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic press
);
  import btn_move_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_r;
  logic             sync2_r;
  logic [1:0]       primed_r;
  logic             arm_r;
  db_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             press_r;

  // Synchronizer, re-arm tracking and debounce FSM.
  always_ff @(posedge clk) begin
    if (!clr) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      primed_r <= 2'b00;
      arm_r    <= 1'b0;
      state_r  <= DB_LO;
      cnt_r    <= {CNT_W{1'b0}};
      level_r  <= 1'b0;
      press_r  <= 1'b0;
    end else begin
      sync1_r  <= raw;
      sync2_r  <= sync1_r;
      primed_r <= {primed_r[0], 1'b1};
      // A button held through reset must be seen released before it counts.
      arm_r    <= arm_r | (primed_r[1] & ~sync2_r);
      press_r  <= 1'b0;
      case (state_r)
        DB_LO: begin
          if (sync2_r && arm_r) begin
            state_r <= DB_WAIT_HI;
            cnt_r   <= CNT_ONE;
          end
        end
        DB_WAIT_HI: begin
          if (!sync2_r) begin
            state_r <= DB_LO;
          end else if (cnt_r == CNT_MAX) begin
            state_r <= DB_HI;
            level_r <= 1'b1;
            press_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DB_HI: begin
          if (!sync2_r) begin
            state_r <= DB_WAIT_LO;
            cnt_r   <= CNT_ONE;
          end
        end
        DB_WAIT_LO: begin
          if (sync2_r) begin
            state_r <= DB_HI;
          end else if (cnt_r == CNT_MAX) begin
            state_r <= DB_LO;
            level_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= DB_LO;
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/btn_move_tx.sv
// Move-command front end: four debounced buttons, priority encoder and a
// 2-entry valid/ready FIFO. Optional auto-repeat under BTN_MOVE_AUTOREPEAT_EN.
module btn_move_tx #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       overflow,
  output logic [3:0] btn_level
);
  import btn_move_pkg::*;

  logic [NUM_BTN-1:0] raw_s;
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] press_s;
  logic [NUM_BTN-1:0] pulse_s;
  move_dir_t          dir_s;
  logic               push_s;
  logic               pop_s;

  move_dir_t          head_r;
  move_dir_t          tail_r;
  logic               valid_r;
  logic               full_r;
  logic               overflow_r;

  assign raw_s = {btnR, btnL, btnD, btnU};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .clr  (clr),
      .raw  (raw_s[i]),
      .level(level_s[i]),
      .press(press_s[i])
    );
  end

`ifdef BTN_MOVE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_ONE   = {{(REP_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] DELAY_M1  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_M1 = REP_W'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] level_prev_r;
  logic [NUM_BTN-1:0] rep_pulse_r;
  logic [REP_W-1:0]   rep_cnt_r;
  logic               rep_first_r;
  logic               one_hot_s;

  assign one_hot_s = $onehot(level_s);

  // Repeat timer: counts cycles since the last press/repeat pulse of the
  // single held button; any level change restarts the initial delay.
  always_ff @(posedge clk) begin
    if (!clr) begin
      level_prev_r <= {NUM_BTN{1'b0}};
      rep_pulse_r  <= {NUM_BTN{1'b0}};
      rep_cnt_r    <= {REP_W{1'b0}};
      rep_first_r  <= 1'b1;
    end else begin
      level_prev_r <= level_s;
      rep_pulse_r  <= {NUM_BTN{1'b0}};
      if ((level_s != level_prev_r) || !one_hot_s) begin
        rep_cnt_r   <= REP_ONE;
        rep_first_r <= 1'b1;
      end else if (rep_cnt_r == (rep_first_r ? DELAY_M1 : PERIOD_M1)) begin
        rep_pulse_r <= level_s;
        rep_cnt_r   <= {REP_W{1'b0}};
        rep_first_r <= 1'b0;
      end else begin
        rep_cnt_r <= rep_cnt_r + REP_ONE;
      end
    end
  end

  assign pulse_s = press_s | rep_pulse_r;
`else
  assign pulse_s = press_s;
`endif

  assign dir_s  = prio_dir(pulse_s);
  assign push_s = |pulse_s;
  assign pop_s  = valid_r & move_ready;

  // Two-entry FIFO with registered head; en low flushes it every cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      head_r     <= DIR_UP;
      tail_r     <= DIR_UP;
      valid_r    <= 1'b0;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (!en) begin
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      case ({full_r, valid_r})
        2'b00: begin
          if (push_s) begin
            head_r  <= dir_s;
            valid_r <= 1'b1;
          end
        end
        2'b01: begin
          if (push_s && pop_s) begin
            head_r <= dir_s;
          end else if (push_s) begin
            tail_r <= dir_s;
            full_r <= 1'b1;
          end else if (pop_s) begin
            valid_r <= 1'b0;
          end
        end
        2'b11: begin
          if (pop_s) begin
            head_r <= tail_r;
            if (push_s) begin
              tail_r <= dir_s;
            end else begin
              full_r <= 1'b0;
            end
          end else if (push_s) begin
            overflow_r <= 1'b1;
          end
        end
        default: begin
          valid_r <= 1'b0;
          full_r  <= 1'b0;
        end
      endcase
    end
  end

  assign move_valid = valid_r;
  assign move_dir   = head_r;
  assign overflow   = overflow_r;
  assign btn_level  = level_s;

endmodule

// File: tb/tb_btn_move_tx.sv
// Scoreboard bench for btn_move_tx: directed button stimulus pushes expected
// moves; a negedge monitor checks every accepted handshake against the queue.
module tb_btn_move_tx;

  localparam int DC = 4;
`ifdef BTN_MOVE_AUTOREPEAT_EN
  localparam int HOLD_LONG = 6;
`else
  localparam int HOLD_LONG = 20;
`endif

  logic       clk = 1'b0;
  logic       clr, en, btnU, btnD, btnL, btnR, move_ready;
  logic       move_valid, overflow;
  logic [1:0] move_dir;
  logic [3:0] btn_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] dir;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_move_tx #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (5),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnL      (btnL),
    .btnR      (btnR),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .move_ready(move_ready),
    .overflow  (overflow),
    .btn_level (btn_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // rel = cycle (relative to the first sampling edge) the move appears; <0 = untimed
  task automatic expect_move(input logic [1:0] d, input int rel);
    exp_t e;
    e.dir = d;
    e.cyc = (rel < 0) ? -1 : cyc + 1 + rel;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    tick(2);
    clr = 1'b1;
  endtask

  task automatic tap(input logic [3:0] m);
    {btnR, btnL, btnD, btnU} = m;
    tick(6);
    {btnR, btnL, btnD, btnU} = 4'b0000;
    tick(10);
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr && move_valid && move_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got dir=%0d at cyc=%0d, required no move", move_dir, cyc);
        end else begin
          e = exp_q.pop_front();
          if (move_dir !== e.dir || (e.cyc >= 0 && cyc != e.cyc)) begin
            bad++;
            $display("FAIL pop_move: got dir=%0d cyc=%0d, required dir=%0d cyc=%0d",
                     move_dir, cyc, e.dir, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    clr = 1'b0; en = 1'b1; move_ready = 1'b0;
    {btnR, btnL, btnD, btnU} = 4'b0000;
    tick(3);
    check("rst_valid", {31'd0, move_valid}, 32'd0);
    check("rst_dir", {30'd0, move_dir}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_level", {28'd0, btn_level}, 32'd0);
    clr = 1'b1;
    tick(4);

    // Bounce: toggles every 2 cycles never reach 4 stable samples.
    move_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btnU = ~btnU;
      tick(2);
    end
    btnU = 1'b0;
    tick(12);
    check("bounce_level", {28'd0, btn_level}, 32'd0);

    // Clean press: level at cycle 6, single move at cycle 7.
    btnL = 1'b1;
    expect_move(2'd2, 7);
    tick(6);
    check("press_level_early", {28'd0, btn_level}, 32'd0);
    tick(1);
    check("press_level", {28'd0, btn_level}, 32'h4);
    tick(1);
    check("press_valid", {31'd0, move_valid}, 32'd1);
    check("press_dir", {30'd0, move_dir}, 32'd2);
    tick(1);
    check("press_popped", {31'd0, move_valid}, 32'd0);
    tick(HOLD_LONG);
    btnL = 1'b0;
    tick(12);
    check("release_level", {28'd0, btn_level}, 32'd0);

    // Backpressure and overflow.
    move_ready = 1'b0;
    tap(4'b0001);
    tap(4'b0010);
    check("bp_no_overflow", {31'd0, overflow}, 32'd0);
    tap(4'b1000);
    check("bp_overflow", {31'd0, overflow}, 32'd1);
    check("bp_valid", {31'd0, move_valid}, 32'd1);
    check("bp_dir_hold", {30'd0, move_dir}, 32'd0);
    expect_move(2'd0, -1);
    expect_move(2'd1, -1);
    move_ready = 1'b1;
    tick(4);
    check("bp_drained", {31'd0, move_valid}, 32'd0);
    check("bp_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Reset clears overflow.
    do_reset();
    tick(1);
    check("rst2_overflow", {31'd0, overflow}, 32'd0);

    // Chord: U and R together -> one move, dir UP, no overflow.
    {btnR, btnU} = 2'b11;
    expect_move(2'd0, 7);
    tick(6);
    {btnR, btnU} = 2'b00;
    tick(12);
    check("chord_overflow", {31'd0, overflow}, 32'd0);

    // en gating: queued moves flushed by a single en=0 cycle.
    move_ready = 1'b0;
    tap(4'b0001);
    tap(4'b0010);
    check("en_queued", {31'd0, move_valid}, 32'd1);
    en = 1'b0;
    tick(1);
    check("en_flush", {31'd0, move_valid}, 32'd0);
    en = 1'b1;
    tick(3);
    check("en_stay_empty", {31'd0, move_valid}, 32'd0);
    move_ready = 1'b1;
`ifndef BTN_MOVE_AUTOREPEAT_EN
    en = 1'b0;
    btnD = 1'b1;
    tick(12);
    en = 1'b1;
    tick(10);
    check("en_held_level", {28'd0, btn_level}, 32'h2);
    check("en_held_nomove", {31'd0, move_valid}, 32'd0);
    btnD = 1'b0;
    tick(12);
`endif
    btnD = 1'b1;
    expect_move(2'd1, 7);
    tick(6);
    btnD = 1'b0;
    tick(12);

    // Reset mid-debounce with the button held: no move until re-pressed.
    btnL = 1'b1;
    tick(4);
    do_reset();
    tick(15);
    check("rst_held_level", {28'd0, btn_level}, 32'd0);
    btnL = 1'b0;
    tick(4);
    btnL = 1'b1;
    expect_move(2'd2, 7);
    tick(6);
    btnL = 1'b0;
    tick(12);

`ifdef BTN_MOVE_AUTOREPEAT_EN
    // Auto-repeat: moves at 7, 15, 19, 23, 27, 31.
    do_reset();
    tick(2);
    btnR = 1'b1;
    expect_move(2'd3, 7);
    expect_move(2'd3, 15);
    expect_move(2'd3, 19);
    expect_move(2'd3, 23);
    expect_move(2'd3, 27);
    expect_move(2'd3, 31);
    tick(27);
    btnR = 1'b0;
    tick(20);
`endif

    tick(2);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
